// File: rtl/fp16_mul_arbiter.sv
// Round-robin sharing of one registered fp16 multiplier between two requesters. Results are
// tagged and steered into per-requester response FIFOs guarded by credits, so none is dropped.
module fp16_mul_arbiter #(
  parameter int MUL_LAT   = 1,
  parameter int RES_DEPTH = 3
) (
  input  logic        CLK,
  input  logic        RESETn,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [15:0] req0_a,
  input  logic [15:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [15:0] req1_a,
  input  logic [15:0] req1_b,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [15:0] rsp0_data,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [15:0] rsp1_data,
  output logic [15:0] mul_a,
  output logic [15:0] mul_b,
  input  logic [15:0] mul_res,
  output logic        busy
);

  localparam int CW = $clog2(RES_DEPTH + 1);
  localparam int PW = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;
  localparam logic [CW-1:0] CRED_MAX = CW'(RES_DEPTH);
  localparam logic [PW-1:0] PTR_LAST = PW'(RES_DEPTH - 1);

  logic                    rr_q, rr_d;
  logic [1:0][CW-1:0]      credit_q, credit_d;
  logic [1:0][CW-1:0]      count_q, count_d;
  logic [1:0][PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [1:0][PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [MUL_LAT-1:0]      tag_vld_q, tag_vld_d;
  logic [MUL_LAT-1:0]      tag_id_q, tag_id_d;
  logic [15:0]             fifo_mem_q [2][RES_DEPTH];

  logic [1:0] req_valid, rsp_ready, elig, grant, push, pop, nonempty, rsp_vld;
  logic       issue, wb_vld, wb_id;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PW'(1);
  endfunction

  assign req_valid = {req1_valid, req0_valid};
  assign rsp_ready = {rsp1_ready, rsp0_ready};

  // Grants are forced low in any reset cycle so nothing issues while state is being cleared.
  assign elig[0]  = req_valid[0] & (credit_q[0] != '0);
  assign elig[1]  = req_valid[1] & (credit_q[1] != '0);
  assign grant[0] = RESETn & elig[0] & (~elig[1] | ~rr_q);
  assign grant[1] = RESETn & elig[1] & (~elig[0] | rr_q);
  assign issue    = grant[0] | grant[1];
  assign rr_d     = issue ? ~grant[1] : rr_q;

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign mul_a = grant[0] ? req0_a : (grant[1] ? req1_a : 16'h0000);
  assign mul_b = grant[0] ? req0_b : (grant[1] ? req1_b : 16'h0000);

  // The tag pipe mirrors the multiplier latency; its output says whose result mul_res is.
  assign tag_vld_d = (tag_vld_q << 1) | MUL_LAT'(issue);
  assign tag_id_d  = (tag_id_q << 1) | MUL_LAT'(grant[1]);
  assign wb_vld    = tag_vld_q[MUL_LAT-1];
  assign wb_id     = tag_id_q[MUL_LAT-1];
  assign push[0]   = wb_vld & ~wb_id;
  assign push[1]   = wb_vld & wb_id;

  assign nonempty[0] = (count_q[0] != '0);
  assign nonempty[1] = (count_q[1] != '0);
  assign rsp_vld     = {2{RESETn}} & nonempty;
  assign pop         = rsp_vld & rsp_ready;

  assign rsp0_valid = rsp_vld[0];
  assign rsp1_valid = rsp_vld[1];
  assign rsp0_data  = rsp_vld[0] ? fifo_mem_q[0][rd_ptr_q[0]] : 16'h0000;
  assign rsp1_data  = rsp_vld[1] ? fifo_mem_q[1][rd_ptr_q[1]] : 16'h0000;
  assign busy       = RESETn & ((|tag_vld_q) | (|nonempty));

  always_comb begin
    // NOTE: defaults first, so every path assigns every output and no latch is inferred.
    credit_d = credit_q;
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    for (int i = 0; i < 2; i++) begin
      case ({grant[i], pop[i]})
        2'b10:   credit_d[i] = credit_q[i] - CW'(1);
        2'b01:   credit_d[i] = credit_q[i] + CW'(1);
        default: credit_d[i] = credit_q[i];
      endcase
      case ({push[i], pop[i]})
        2'b10:   count_d[i] = count_q[i] + CW'(1);
        2'b01:   count_d[i] = count_q[i] - CW'(1);
        default: count_d[i] = count_q[i];
      endcase
      if (push[i]) wr_ptr_d[i] = ptr_inc(wr_ptr_q[i]);
      if (pop[i])  rd_ptr_d[i] = ptr_inc(rd_ptr_q[i]);
    end
  end

  always_ff @(posedge CLK) begin
    // NOTE: non-blocking assignments so every register samples the pre-edge values.
    if (!RESETn) begin
      rr_q      <= 1'b0;
      credit_q  <= {2{CRED_MAX}};
      count_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      tag_vld_q <= '0;
      tag_id_q  <= '0;
    end else begin
      rr_q      <= rr_d;
      credit_q  <= credit_d;
      count_q   <= count_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      tag_vld_q <= tag_vld_d;
      tag_id_q  <= tag_id_d;
    end
  end

  // NOTE: the FIFO storage is not reset; the occupancy counters alone decide what is readable.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < 2; i++) begin
      if (push[i]) fifo_mem_q[i][wr_ptr_q[i]] <= mul_res;
    end
  end

endmodule

// File: tb/tb_fp16_mul_arbiter.sv
// Directed bench for fp16_mul_arbiter: reset, single op, contention, backpressure,
// mid-operation reset and single-requester throughput, against hand-computed fp16 products.
module tb_fp16_mul_arbiter;

  logic        CLK, RESETn;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [15:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [15:0] rsp0_data, rsp1_data;
  logic [15:0] mul_a, mul_b, mul_res;
  logic        busy;

  int n_cmp;
  int n_err;

  fp16_mul_arbiter #(.MUL_LAT(1), .RES_DEPTH(3)) dut (
    .CLK(CLK), .RESETn(RESETn),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
    .mul_a(mul_a), .mul_b(mul_b), .mul_res(mul_res), .busy(busy)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Products for the operand pairs used below, worked out by hand (1.0 = 3C00).
  function automatic logic [15:0] fp_mul_ref(input logic [15:0] a, input logic [15:0] b);
    if (a == 16'h0000 || b == 16'h0000)      return 16'h0000;
    if (a == 16'h3C00)                       return b;
    if (b == 16'h3C00)                       return a;
    if (a == 16'h4000 && b == 16'h4200)      return 16'h4600;
    if (a == 16'h4000 && b == 16'h4000)      return 16'h4400;
    return 16'h7E00;
  endfunction

  // Registered single-cycle multiplier model.
  always @(posedge CLK) mul_res <= fp_mul_ref(mul_a, mul_b);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic drain(input string tag);
    for (int n = 0; n < 20 && busy; n++) begin
      cyc();
      #1;
    end
    check(tag, busy, 1'b0);
  endtask

  task automatic do_reset();
    cyc();
    RESETn = 1'b0;
    cyc();
    RESETn = 1'b1;
  endtask

  task automatic reset_quiet(input string tag);
    check({tag, "_r0rdy"}, req0_ready, 1'b0);
    check({tag, "_r1rdy"}, req1_ready, 1'b0);
    check({tag, "_s0vld"}, rsp0_valid, 1'b0);
    check({tag, "_s1vld"}, rsp1_valid, 1'b0);
    check({tag, "_busy"},  busy, 1'b0);
    check({tag, "_mula"},  mul_a, 16'h0000);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    RESETn = 1'b0;
    req0_valid = 1'b1; req0_a = 16'h3C00; req0_b = 16'h4000;
    req1_valid = 1'b1; req1_a = 16'h3C00; req1_b = 16'hBC00;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;

    // Reset held for two cycles with both requesters asking.
    #2;
    reset_quiet("rst_c0");
    cyc(); #1;
    reset_quiet("rst_c1");
    cyc();
    RESETn = 1'b1;
    #1;
    check("rel_r0rdy", req0_ready, 1'b1);
    check("rel_r1rdy", req1_ready, 1'b0);
    check("rel_mulb",  mul_b, 16'h4000);
    cyc(); #1;
    check("rel2_r0rdy", req0_ready, 1'b0);
    check("rel2_r1rdy", req1_ready, 1'b1);
    check("rel2_mulb",  mul_b, 16'hBC00);
    cyc();
    req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
    drain("rel_drain");

    // Single op: 1.0 * 2.0.
    cyc();
    req0_valid = 1'b1; req0_a = 16'h3C00; req0_b = 16'h4000;
    #1;
    check("one_rdy",  req0_ready, 1'b1);
    check("one_mula", mul_a, 16'h3C00);
    check("one_mulb", mul_b, 16'h4000);
    cyc();
    req0_valid = 1'b0;
    #1;
    check("one_t1_vld",  rsp0_valid, 1'b0);
    check("one_t1_busy", busy, 1'b1);
    cyc(); #1;
    check("one_t2_vld",  rsp0_valid, 1'b1);
    check("one_t2_data", rsp0_data, 16'h4000);
    check("one_t2_busy", busy, 1'b1);
    cyc(); #1;
    check("one_t3_busy", busy, 1'b0);
    check("one_t3_vld",  rsp0_valid, 1'b0);

    // Contention: 2*3 on port 0, 1*-1 on port 1.
    do_reset();
    req0_a = 16'h4000; req0_b = 16'h4200;
    req1_a = 16'h3C00; req1_b = 16'hBC00;
    for (int k = 0; k < 10; k++) begin
      cyc();
      req0_valid = (k < 8);
      req1_valid = (k < 8);
      #1;
      if (k < 8) begin
        check($sformatf("con%0d_r0rdy", k), req0_ready, (k % 2) == 0);
        check($sformatf("con%0d_r1rdy", k), req1_ready, (k % 2) == 1);
        check($sformatf("con%0d_mula", k), mul_a, (k % 2) == 0 ? 16'h4000 : 16'h3C00);
      end
      if (k >= 2) begin
        check($sformatf("con%0d_s0vld", k), rsp0_valid, (k % 2) == 0);
        check($sformatf("con%0d_s1vld", k), rsp1_valid, (k % 2) == 1);
        if (k % 2 == 0) check($sformatf("con%0d_s0dat", k), rsp0_data, 16'h4600);
        else            check($sformatf("con%0d_s1dat", k), rsp1_data, 16'hBC00);
      end
    end
    drain("con_drain");

    // Backpressure on port 0: three credits, then port 1 owns the multiplier.
    do_reset();
    req0_a = 16'h4000; req0_b = 16'h4000;
    for (int k = 0; k < 16; k++) begin
      cyc();
      req0_valid = (k <= 13);
      req1_valid = (k <= 13);
      rsp0_ready = (k >= 12);
      #1;
      check($sformatf("bp%0d_r0rdy", k), req0_ready, (k == 0 || k == 2 || k == 4 || k == 13));
      check($sformatf("bp%0d_r1rdy", k), req1_ready, (k == 1 || k == 3 || (k >= 5 && k <= 12)));
      if (k >= 2) begin
        check($sformatf("bp%0d_s0vld", k), rsp0_valid, 1'b1);
        check($sformatf("bp%0d_s0dat", k), rsp0_data, 16'h4400);
      end
    end
    rsp0_ready = 1'b1;
    drain("bp_drain");

    // Reset one cycle after two issues: those results must never surface.
    req0_a = 16'h3C00; req0_b = 16'h4200;
    for (int m = 0; m < 8; m++) begin
      cyc();
      RESETn = (m != 2);
      req0_valid = 1'b1;
      if (m >= 2) begin
        req0_a = 16'h4000; req0_b = 16'h4000;
      end
      if (m >= 3) rsp0_ready = 1'b0;
      #1;
      if (m < 2) begin
        check($sformatf("mr%0d_r0rdy", m), req0_ready, 1'b1);
      end else if (m == 2) begin
        reset_quiet("mr2");
      end else begin
        check($sformatf("mr%0d_r0rdy", m), req0_ready, m <= 5);
        check($sformatf("mr%0d_s0vld", m), rsp0_valid, m >= 5);
        if (m >= 5) check($sformatf("mr%0d_s0dat", m), rsp0_data, 16'h4400);
      end
    end
    req0_valid = 1'b0;
    rsp0_ready = 1'b1;
    drain("mr_drain");

    // Throughput: eight back-to-back ops on port 1, results in issue order.
    for (int p = 0; p < 11; p++) begin
      cyc();
      req1_valid = (p < 8);
      req1_a = 16'h3C00;
      req1_b = 16'h4000 + (16'(p) << 8);
      #1;
      if (p < 8) check($sformatf("tp%0d_r1rdy", p), req1_ready, 1'b1);
      check($sformatf("tp%0d_s1vld", p), rsp1_valid, (p >= 2 && p < 10));
      if (p >= 2 && p < 10)
        check($sformatf("tp%0d_s1dat", p), rsp1_data, 16'h4000 + (16'(p - 2) << 8));
    end
    drain("tp_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
